// File: rtl/l15_resp_model.sv
// rtl/l15_resp_model.sv - L1.5-style memory responder with in-order, latency-timed return queue
// Requests are fully resolved against the backing RAM at accept; responses wait out LATENCY in a FIFO.
module l15_resp_model #(
   parameter int MEM_AW     = 10,
   parameter int PEND_DEPTH = 8,
   parameter int LATENCY    = 4,
   parameter int TID_W      = 2,
   parameter int ADDR_W     = 40
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          req_val_i,
   output logic                          req_ack_o,
   input  logic [4:0]                    req_type_i,
   input  logic                          req_nc_i,
   input  logic [TID_W-1:0]              req_tid_i,
   input  logic [ADDR_W-1:0]             req_addr_i,
   input  logic [2:0]                    req_size_i,
   input  logic [63:0]                   req_data_i,
   output logic                          rtrn_val_o,
   input  logic                          rtrn_ack_i,
   output logic [3:0]                    rtrn_type_o,
   output logic [TID_W-1:0]              rtrn_tid_o,
   output logic [127:0]                  rtrn_data_o,
   output logic [$clog2(PEND_DEPTH):0]   pend_cnt_o,
   output logic                          err_o
);
   localparam int PW = $clog2(PEND_DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(PEND_DEPTH);
   localparam logic [LW-1:0] LAT_C   = LW'(LATENCY);
   localparam logic [4:0] T_LOAD  = 5'b00000;
   localparam logic [4:0] T_IMISS = 5'b10000;
   localparam logic [4:0] T_STORE = 5'b00001;
   localparam logic [3:0] R_LOAD  = 4'b0000;
   localparam logic [3:0] R_IFILL = 4'b0001;
   localparam logic [3:0] R_STACK = 4'b0100;

   function automatic logic [63:0] f_bswap(input logic [63:0] d);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(7-k) +: 8];
      return r;
   endfunction

   logic [63:0]      r_mem    [0:(1<<MEM_AW)-1];
   logic [3:0]       r_q_type [0:PEND_DEPTH-1];
   logic [TID_W-1:0] r_q_tid  [0:PEND_DEPTH-1];
   logic [127:0]     r_q_data [0:PEND_DEPTH-1];
   logic [LW-1:0]    r_q_cnt  [0:PEND_DEPTH-1];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_cnt;
   logic             r_rtrn_val, r_err;
   logic [3:0]       r_rtrn_type;
   logic [TID_W-1:0] r_rtrn_tid;
   logic [127:0]     r_rtrn_data;

   logic              w_acc, w_push, w_pop, w_bad, w_store, w_unused;
   logic [MEM_AW-1:0] w_idx, w_idx_even, w_idx_odd;
   logic [63:0]       w_rd_addr, w_rd_even, w_rd_odd, w_wdata;
   logic [2:0]        w_mask, w_off;
   logic [7:0]        w_be_base, w_be;
   logic [3:0]        w_etype;
   logic [127:0]      w_edata;

   assign w_unused   = ^req_addr_i[ADDR_W-1:MEM_AW+3];
   assign w_acc      = req_val_i & (r_cnt < DEPTH_C);
   assign req_ack_o  = w_acc;
   assign w_idx      = req_addr_i[MEM_AW+2:3];
   assign w_idx_even = {w_idx[MEM_AW-1:1], 1'b0};
   assign w_idx_odd  = {w_idx[MEM_AW-1:1], 1'b1};
   assign w_rd_addr  = r_mem[w_idx];
   assign w_rd_even  = r_mem[w_idx_even];
   assign w_rd_odd   = r_mem[w_idx_odd];
   assign w_wdata    = f_bswap(req_data_i);

   always_comb begin
      w_push  = 1'b0;
      w_bad   = 1'b0;
      w_store = 1'b0;
      w_etype = R_LOAD;
      w_edata = '0;
      case (req_type_i)
         T_LOAD: begin
            w_push  = w_acc;
            w_etype = R_LOAD;
            w_edata = req_nc_i ? {f_bswap(w_rd_addr), f_bswap(w_rd_addr)}
                               : {f_bswap(w_rd_odd), f_bswap(w_rd_even)};
         end
         T_IMISS: begin
            w_push  = w_acc;
            w_etype = R_IFILL;
            w_edata = {f_bswap(w_rd_odd), f_bswap(w_rd_even)};
         end
         T_STORE: begin
            w_push  = w_acc;
            w_store = w_acc;
            w_etype = R_STACK;
         end
         default: w_bad = w_acc;
      endcase
   end

   // Misaligned offsets are rounded down to the access size before building lane enables.
   always_comb begin
      w_mask    = 3'b000;
      w_be_base = 8'hFF;
      case (req_size_i)
         3'd0:    begin w_mask = 3'b111; w_be_base = 8'h01; end
         3'd1:    begin w_mask = 3'b110; w_be_base = 8'h03; end
         3'd2:    begin w_mask = 3'b100; w_be_base = 8'h0F; end
         default: begin w_mask = 3'b000; w_be_base = 8'hFF; end
      endcase
   end

   assign w_off = req_addr_i[2:0] & w_mask;
   assign w_be  = w_be_base << w_off;

   always_ff @(posedge clk_i) begin
      if (w_store) begin
         for (int k = 0; k < 8; k++) begin
            if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_q_type[r_wr_ptr] <= w_etype;
         r_q_tid[r_wr_ptr]  <= req_tid_i;
         r_q_data[r_wr_ptr] <= w_edata;
      end
      for (int i = 0; i < PEND_DEPTH; i++) begin
         if (w_push && r_wr_ptr == PW'(i)) r_q_cnt[i] <= LAT_C;
         else if (r_q_cnt[i] != '0)         r_q_cnt[i] <= r_q_cnt[i] - LW'(1);
      end
   end

   assign w_pop = (r_cnt != '0) && (r_q_cnt[r_rd_ptr] == '0) && (!r_rtrn_val || rtrn_ack_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_rtrn_val  <= 1'b0;
         r_rtrn_type <= '0;
         r_rtrn_tid  <= '0;
         r_rtrn_data <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (w_bad) r_err <= 1'b1;
         if (w_pop) begin
            r_rtrn_val  <= 1'b1;
            r_rtrn_type <= r_q_type[r_rd_ptr];
            r_rtrn_tid  <= r_q_tid[r_rd_ptr];
            r_rtrn_data <= r_q_data[r_rd_ptr];
         end else if (rtrn_ack_i) begin
            r_rtrn_val  <= 1'b0;
         end
      end
   end

   assign rtrn_val_o  = r_rtrn_val;
   assign rtrn_type_o = r_rtrn_type;
   assign rtrn_tid_o  = r_rtrn_tid;
   assign rtrn_data_o = r_rtrn_data;
   assign pend_cnt_o  = r_cnt;
   assign err_o       = r_err;
endmodule

// File: tb/tb_l15_resp_model.sv
// tb/tb_l15_resp_model.sv - directed and random checks of l15_resp_model against a byte-level memory model
// Expected responses are queued at accept time and compared at each response handshake.
module tb_l15_resp_model;
   localparam int LAT = 4;
   localparam logic [4:0] T_LOAD  = 5'b00000;
   localparam logic [4:0] T_IMISS = 5'b10000;
   localparam logic [4:0] T_STORE = 5'b00001;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_val, req_ack, req_nc, rtrn_val, rtrn_ack, err;
   logic [4:0]   req_type;
   logic [1:0]   req_tid, rtrn_tid;
   logic [39:0]  req_addr;
   logic [2:0]   req_size;
   logic [63:0]  req_data;
   logic [3:0]   rtrn_type;
   logic [127:0] rtrn_data;
   logic [3:0]   pend;

   typedef struct {
      logic [3:0]   t;
      logic [1:0]   tid;
      logic [127:0] d;
   } rsp_t;

   rsp_t       exp_q[$];
   logic [7:0] mb [0:8191];
   int         n_vec = 0;
   int         n_err = 0;
   logic       err_exp;
   logic       last_acc;

   always #5 clk = ~clk;

   l15_resp_model #(.MEM_AW(10), .PEND_DEPTH(8), .LATENCY(LAT), .TID_W(2), .ADDR_W(40)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_val_i(req_val), .req_ack_o(req_ack), .req_type_i(req_type), .req_nc_i(req_nc),
      .req_tid_i(req_tid), .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data),
      .rtrn_val_o(rtrn_val), .rtrn_ack_i(rtrn_ack), .rtrn_type_o(rtrn_type), .rtrn_tid_o(rtrn_tid),
      .rtrn_data_o(rtrn_data), .pend_cnt_o(pend), .err_o(err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] be_word(input int base);
      logic [63:0] v;
      for (int j = 0; j < 8; j++) v[63-8*j -: 8] = mb[(base + j) & 8191];
      return v;
   endfunction

   task automatic model_accept();
      int a, nb, st;
      logic [63:0] d64;
      rsp_t r;
      a     = int'(req_addr[12:0]);
      r.tid = req_tid;
      r.d   = '0;
      r.t   = 4'b0000;
      case (req_type)
         T_STORE: begin
            nb = 1 << int'(req_size);
            st = a & ~(nb - 1);
            for (int j = 0; j < nb; j++) mb[(st + j) & 8191] = req_data[63 - 8*((st + j) % 8) -: 8];
            r.t = 4'b0100;
            exp_q.push_back(r);
         end
         T_LOAD: begin
            if (req_nc) begin
               d64 = be_word(a & ~7);
               r.d = {d64, d64};
            end else begin
               r.d = {be_word((a & ~15) + 8), be_word(a & ~15)};
            end
            exp_q.push_back(r);
         end
         T_IMISS: begin
            r.t = 4'b0001;
            r.d = {be_word((a & ~15) + 8), be_word(a & ~15)};
            exp_q.push_back(r);
         end
         default: err_exp = 1'b1;
      endcase
   endtask

   task automatic step();
      rsp_t e;
      @(negedge clk);
      last_acc = 1'b0;
      if (rtrn_val && rtrn_ack) begin
         chk("rtrn_expected", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rtrn_type", 128'(rtrn_type), 128'(e.t));
            chk("rtrn_tid", 128'(rtrn_tid), 128'(e.tid));
            chk("rtrn_data", rtrn_data, e.d);
         end
      end
      if (req_val && req_ack) begin
         model_accept();
         last_acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] t, input logic nc, input logic [1:0] tid,
                       input logic [39:0] a, input logic [2:0] sz, input logic [63:0] d);
      req_type = t; req_nc = nc; req_tid = tid; req_addr = a; req_size = sz; req_data = d;
      req_val  = 1'b1;
      for (int c = 0; c < 200; c++) begin
         step();
         if (last_acc) break;
      end
      chk("send_accepted", 128'(last_acc), 128'd1);
      req_val = 1'b0;
   endtask

   task automatic wait_rsp();
      for (int c = 0; c < 50 && !rtrn_val; c++) step();
      chk("rsp_timeout", 128'(rtrn_val), 128'd1);
   endtask

   task automatic drain();
      req_val  = 1'b0;
      rtrn_ack = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (exp_q.size() == 0 && !rtrn_val) break;
         step();
      end
      chk("drain_done", 128'(exp_q.size()), 128'd0);
      chk("drain_idle", 128'(rtrn_val), 128'd0);
      rtrn_ack = 1'b0;
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; req_val = 1'b0; rtrn_ack = 1'b0; err_exp = 1'b0; last_acc = 1'b0;
      req_type = '0; req_nc = 1'b0; req_tid = '0; req_addr = '0; req_size = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_pend", 128'(pend), 128'd0);
      chk("rst_val", 128'(rtrn_val), 128'd0);
      chk("rst_type", 128'(rtrn_type), 128'd0);
      chk("rst_tid", 128'(rtrn_tid), 128'd0);
      chk("rst_data", rtrn_data, 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_req_ack", 128'(req_ack), 128'd0);

      rtrn_ack = 1'b1;
      for (int w = 0; w < 64; w++) send(T_STORE, 1'b0, 2'd0, 40'(w * 8), 3'd3, {$urandom, $urandom});
      drain();

      // Store then cached load, with exact response latency.
      send(T_STORE, 1'b0, 2'd1, 40'h100, 3'd3, 64'h0011223344556677);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (rtrn_val) begin lat = c; break; end
      end
      chk("st_ack_latency", 128'(lat), 128'(LAT + 1));
      chk("st_ack_type", 128'(rtrn_type), 128'h4);
      chk("st_ack_tid", 128'(rtrn_tid), 128'd1);
      rtrn_ack = 1'b1; step(); rtrn_ack = 1'b0;
      send(T_LOAD, 1'b0, 2'd2, 40'h100, 3'd3, 64'd0);
      wait_rsp();
      chk("ld_data_lo", 128'(rtrn_data[63:0]), 128'(64'h0011223344556677));
      rtrn_ack = 1'b1; step(); rtrn_ack = 1'b0;

      // Byte store into big-endian lane 3, read back non-cacheable.
      send(T_STORE, 1'b0, 2'd3, 40'h103, 3'd0, 64'hFFFFFFAB_FFFFFFFF);
      drain();
      send(T_LOAD, 1'b1, 2'd0, 40'h100, 3'd3, 64'd0);
      wait_rsp();
      chk("nc_byte_data", rtrn_data, {2{64'h001122AB44556677}});
      rtrn_ack = 1'b1; step(); rtrn_ack = 1'b0;

      // Fill the queue behind a held response, then drain back-to-back.
      send(T_LOAD, 1'b0, 2'd3, 40'h40, 3'd3, 64'd0);
      wait_rsp();
      for (int i = 0; i < 9; i++) begin
         req_type = T_LOAD; req_nc = 1'b0; req_tid = 2'(i % 4); req_addr = 40'(i * 16);
         req_val  = 1'b1;
         #1;
         if (i < 8) begin
            chk("fill_ack", 128'(req_ack), 128'd1);
            step();
         end else begin
            chk("full_ack", 128'(req_ack), 128'd0);
            chk("full_pend", 128'(pend), 128'd8);
         end
      end
      repeat (3) step();
      chk("full_hold_ack", 128'(req_ack), 128'd0);
      rtrn_ack = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("no_gap", 128'(rtrn_val), 128'd1);
         step();
         if (last_acc) req_val = 1'b0;
      end
      drain();

      // Load data is captured at accept, before a younger store.
      send(T_LOAD, 1'b0, 2'd1, 40'h108, 3'd3, 64'd0);
      send(T_STORE, 1'b0, 2'd2, 40'h108, 3'd3, 64'hDEADBEEF_CAFEF00D);
      send(T_LOAD, 1'b0, 2'd3, 40'h108, 3'd3, 64'd0);
      drain();

      // Aliased instruction fill and unsupported request type.
      send(T_IMISS, 1'b0, 2'd0, 40'h2000, 3'd3, 64'd0);
      wait_rsp();
      chk("imiss_type", 128'(rtrn_type), 128'h1);
      chk("imiss_alias_data", rtrn_data, {be_word(8), be_word(0)});
      rtrn_ack = 1'b1; step(); rtrn_ack = 1'b0;
      send(5'b00010, 1'b0, 2'd1, 40'h0, 3'd3, 64'd0);
      repeat (LAT + 3) step();
      chk("bad_err", 128'(err), 128'd1);
      chk("bad_no_rsp", 128'(rtrn_val), 128'd0);
      chk("bad_pend", 128'(pend), 128'd0);

      // Random traffic with random backpressure.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 2))
            0:       req_type = T_LOAD;
            1:       req_type = T_IMISS;
            default: req_type = T_STORE;
         endcase
         req_val  = 1'($urandom_range(0, 1));
         req_nc   = 1'($urandom_range(0, 1));
         req_tid  = 2'($urandom_range(0, 3));
         req_addr = 40'($urandom_range(0, 511)) | (40'($urandom_range(0, 3)) << 13) | (40'($urandom) << 20);
         req_size = 3'($urandom_range(0, 3));
         req_data = {$urandom, $urandom};
         rtrn_ack = 1'($urandom_range(0, 1));
         step();
      end
      drain();
      chk("err_sticky", 128'(err), 128'(err_exp));

      // Reset with entries pending and a response held.
      for (int i = 0; i < 6; i++) send(T_LOAD, 1'b0, 2'(i), 40'(i * 8), 3'd3, 64'd0);
      wait_rsp();
      chk("pre_rst_pend", 128'(pend), 128'd5);
      rst_n = 1'b0;
      #1;
      err_exp = 1'b0;
      exp_q.delete();
      chk("mid_rst_val", 128'(rtrn_val), 128'd0);
      chk("mid_rst_pend", 128'(pend), 128'd0);
      chk("mid_rst_type", 128'(rtrn_type), 128'd0);
      chk("mid_rst_tid", 128'(rtrn_tid), 128'd0);
      chk("mid_rst_data", rtrn_data, 128'd0);
      chk("mid_rst_err", 128'(err), 128'(err_exp));
      step();
      rst_n = 1'b1;
      step();
      send(T_LOAD, 1'b1, 2'd2, 40'h100, 3'd3, 64'd0);
      wait_rsp();
      chk("post_rst_ram", rtrn_data, {be_word(256), be_word(256)});
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
